draw_cards: RTL and testbench
=============================

// Module: draw_cards
// PURPOSE
//  Plots up to three cards as filled squares on the 3x3 card grid of the 160x120 VGA frame.
//  It is the drawing counterpart of the card-erase path: same slot encoding (4-bit index 1..9),
//  same grid geometry, same pixel-stream output (x, y, colour, plot) to the VGA adapter.
//  Driven by the game controller with a start pulse; done pulses when all three slots are drawn.
// PARAMETERS
//  CARD_W      16      card width in pixels (1..16)
//  CARD_H      16      card height in pixels (1..16)
//  X_ORG       50      x of slot 1 top-left corner
//  Y_ORG       30      y of slot 1 top-left corner
//  PITCH       20      slot spacing in x and y; X_ORG+2*PITCH+CARD_W-1 <= 159, Y_ORG+2*PITCH+CARD_H-1 <= 119
//  BORDER_COL  3'b111  colour of the 1-pixel card outline
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   asynchronous, active-low reset
//  start        in   1   1-cycle request; honoured only in IDLE
//  card_idx     in   12  slot indices: [3:0] card0, [7:4] card1, [11:8] card2
//  card_colour  in   9   fill colours: [2:0] card0, [5:3] card1, [8:6] card2
//  x            out  8   pixel x
//  y            out  7   pixel y
//  colour       out  3   pixel colour
//  plot         out  1   pixel write enable for VGA adapter
//  busy         out  1   high from the cycle after start is accepted until done
//  done         out  1   1-cycle completion pulse
// BEHAVIOUR
//  - Reset (async, any state): FSM->IDLE; x=0, y=0, colour=0, plot=0, busy=0, done=0; counters cleared.
//  - Outputs are decoded from registered state/counters; when plot=0, x, y and colour are 0.
//  - Slot map: idx 1..9 -> col=(idx-1)%3, row=(idx-1)/3; x0=X_ORG+col*PITCH, y0=Y_ORG+row*PITCH.
//  - FSM: IDLE -> LOAD -> DRAW -> NEXT -> (LOAD | DONE) -> IDLE.
//    IDLE: start=1 latches card_idx and card_colour, sets sel=0 -> LOAD.
//      Later changes on the inputs are ignored until the next accepted start.
//    LOAD (1 cycle): compute x0/y0 for card[sel]; px=py=0.
//      Index valid (1..9) -> DRAW; index 0 or 10..15 -> NEXT (card skipped, no pixels).
//    DRAW: plot=1, x=x0+px, y=y0+py.
//      colour=BORDER_COL if px==0, px==CARD_W-1, py==0 or py==CARD_H-1; else card_colour[sel].
//      Each cycle px++; at px==CARD_W-1, px wraps to 0 and py++.
//      After the pixel (CARD_W-1, CARD_H-1) -> NEXT. Raster order: row-major, top-left first.
//    NEXT (1 cycle): sel==2 -> DONE, else sel++ -> LOAD.
//    DONE (1 cycle): done=1, busy=0 -> IDLE.
//  - busy=1 in LOAD, DRAW and NEXT.
//  - start while not IDLE: ignored, with no queueing. start in the same cycle as DONE: ignored.
//  - start in the first IDLE cycle after DONE: accepted.
//  - Timing: start sampled at edge E0; LOAD on E1; first plot on E2.
//    A valid card costs CARD_W*CARD_H+2 cycles; an invalid card costs 2 cycles.
//    Three valid 16x16 cards: done is high for the cycle starting at E775.
//  - Duplicate indices are drawn again with no error. The last card drawn wins overlapping pixels.
//  - Reset mid-DRAW aborts immediately: plot drops asynchronously and no done is produced.
// TESTING
//  1. idx={9,5,1}, colours={blue,green,red} -> 768 plots.
//     First pixel (50,30) is BORDER_COL; pixel (51,31) is red; last pixel (105,85).
//     done is high for exactly 1 cycle at E775.
//  2. idx={0,12,4} -> only slot 4 drawn (256 plots, x 50..65, y 50..65); done at E263.
//  3. start pulsed 10 times during busy, with card_idx changed mid-draw
//     -> output identical to an undisturbed run; a single done.
//  4. reset_n low at plot #100 of card1 -> all outputs 0 in the same cycle.
//     After release, FSM is in IDLE; a new start draws from card0.
//  5. start on the cycle after done -> accepted; second sequence is cycle-identical to the first.
//  6. Scoreboard every plotted (x,y,colour) against the model.
//     Check: no plot outside the grid bounds; plot=0 implies x=y=colour=0.

Source files
------------

// File: rtl/draw_cards.sv
// -----------------------------------------------------------------------------
// draw_cards
//   Plots up to three cards as filled squares on the 3x3 card grid of the
//   160x120 VGA frame. Each card occupies one slot (index 1..9, row-major from
//   the top-left slot). It has a 1-pixel outline in BORDER_COL and is filled
//   with its own colour. Pixels stream out one per cycle in row-major order.
//   Slots with index 0 or 10..15 are skipped and produce no pixels.
//
// Ports
//   clk            system clock
//   reset_n        asynchronous, active-low reset
//   i_start        1-cycle draw request, honoured only while idle
//   i_card_idx     slot indices: [3:0] card0, [7:4] card1, [11:8] card2
//   i_card_colour  fill colours: [2:0] card0, [5:3] card1, [8:6] card2
//   o_x, o_y       pixel coordinate (0 when o_plot is low)
//   o_colour       pixel colour (0 when o_plot is low)
//   o_plot         pixel write enable for the VGA adapter
//   o_busy         high while cards are being loaded, drawn or advanced
//   o_done         1-cycle pulse once all three slots have been handled
// -----------------------------------------------------------------------------
module draw_cards #(
  parameter int          CARD_W     = 16,
  parameter int          CARD_H     = 16,
  parameter int          X_ORG      = 50,
  parameter int          Y_ORG      = 30,
  parameter int          PITCH      = 20,
  parameter logic [2:0]  BORDER_COL = 3'b111
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_start,
  input  logic [11:0] i_card_idx,
  input  logic [8:0]  i_card_colour,
  output logic [7:0]  o_x,
  output logic [6:0]  o_y,
  output logic [2:0]  o_colour,
  output logic        o_plot,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [3:0] LAST_PX = 4'(CARD_W - 1);
  localparam logic [3:0] LAST_PY = 4'(CARD_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAW,
    S_NEXT,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  // r_accepted marks the cycle between capturing a request and entering LOAD,
  // so the request and its data are taken together from the same edge.
  logic        r_accepted;
  logic [11:0] r_idx;
  logic [8:0]  r_col;
  logic [1:0]  r_sel;
  logic [7:0]  r_x0;
  logic [6:0]  r_y0;
  logic [3:0]  r_px;
  logic [3:0]  r_py;

  logic [3:0]  w_curIdx;
  logic [2:0]  w_fill;
  logic        w_idxValid;
  logic [1:0]  w_col;
  logic [1:0]  w_row;
  logic        w_lastPx;
  logic        w_lastPy;
  logic        w_plot;
  logic        w_onBorder;

  // Select the index and fill colour of the card currently being handled.
  always_comb begin
    w_curIdx = i_card_idx[3:0] & 4'h0;
    w_fill   = 3'd0;
    case (r_sel)
      2'd0: begin
        w_curIdx = r_idx[3:0];
        w_fill   = r_col[2:0];
      end
      2'd1: begin
        w_curIdx = r_idx[7:4];
        w_fill   = r_col[5:3];
      end
      default: begin
        w_curIdx = r_idx[11:8];
        w_fill   = r_col[8:6];
      end
    endcase
  end

  assign w_idxValid = (w_curIdx >= 4'd1) && (w_curIdx <= 4'd9);

  // Slot index to grid column/row; invalid indices map to slot 1 but are never drawn.
  always_comb begin
    w_col = 2'd0;
    w_row = 2'd0;
    case (w_curIdx)
      4'd2: w_col = 2'd1;
      4'd3: w_col = 2'd2;
      4'd4: w_row = 2'd1;
      4'd5: begin w_col = 2'd1; w_row = 2'd1; end
      4'd6: begin w_col = 2'd2; w_row = 2'd1; end
      4'd7: w_row = 2'd2;
      4'd8: begin w_col = 2'd1; w_row = 2'd2; end
      4'd9: begin w_col = 2'd2; w_row = 2'd2; end
      default: ;
    endcase
  end

  assign w_lastPx = (r_px == LAST_PX);
  assign w_lastPy = (r_py == LAST_PY);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_nextState;
  end

  // Next-state decode.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (r_accepted) w_nextState = S_LOAD;
      S_LOAD: w_nextState = w_idxValid ? S_DRAW : S_NEXT;
      S_DRAW: if (w_lastPx && w_lastPy) w_nextState = S_NEXT;
      S_NEXT: w_nextState = (r_sel == 2'd2) ? S_DONE : S_LOAD;
      S_DONE: w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Request capture, card origin computation and raster counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_accepted <= 1'b0;
      r_idx      <= '0;
      r_col      <= '0;
      r_sel      <= '0;
      r_x0       <= '0;
      r_y0       <= '0;
      r_px       <= '0;
      r_py       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_accepted) begin
            r_accepted <= 1'b0;
          end else if (i_start) begin
            r_accepted <= 1'b1;
            r_idx      <= i_card_idx;
            r_col      <= i_card_colour;
            r_sel      <= 2'd0;
          end
        end
        S_LOAD: begin
          r_x0 <= 8'(X_ORG + PITCH * int'(w_col));
          r_y0 <= 7'(Y_ORG + PITCH * int'(w_row));
          r_px <= 4'd0;
          r_py <= 4'd0;
        end
        S_DRAW: begin
          if (w_lastPx) begin
            r_px <= 4'd0;
            r_py <= r_py + 4'd1;
          end else begin
            r_px <= r_px + 4'd1;
          end
        end
        S_NEXT: begin
          if (r_sel != 2'd2) r_sel <= r_sel + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign w_plot     = (r_state == S_DRAW);
  assign w_onBorder = (r_px == 4'd0) || w_lastPx || (r_py == 4'd0) || w_lastPy;

  // Pixel outputs are forced to zero whenever nothing is being plotted.
  always_comb begin
    o_x      = 8'd0;
    o_y      = 7'd0;
    o_colour = 3'd0;
    if (w_plot) begin
      o_x      = r_x0 + {4'd0, r_px};
      o_y      = r_y0 + {3'd0, r_py};
      o_colour = w_onBorder ? BORDER_COL : w_fill;
    end
  end

  assign o_plot = w_plot;
  assign o_busy = (r_state == S_LOAD) || (r_state == S_DRAW) || (r_state == S_NEXT);
  assign o_done = (r_state == S_DONE);

endmodule

// File: tb/tb_draw_cards.sv
// -----------------------------------------------------------------------------
// tb_draw_cards
//   Self-checking bench for draw_cards. A reference model computes, from the
//   slot/geometry rules, the expected output on every cycle after a request is
//   sampled (pixel stream, busy, done). The DUT is compared cycle by cycle.
// -----------------------------------------------------------------------------
module tb_draw_cards;

  localparam int         CARD_W     = 16;
  localparam int         CARD_H     = 16;
  localparam int         X_ORG      = 50;
  localparam int         Y_ORG      = 30;
  localparam int         PITCH      = 20;
  localparam logic [2:0] BORDER_COL = 3'b111;
  localparam int         X_MAX      = X_ORG + 2 * PITCH + CARD_W - 1;
  localparam int         Y_MAX      = Y_ORG + 2 * PITCH + CARD_H - 1;
  localparam int         DEPTH      = 1024;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_start;
  logic [11:0] i_card_idx;
  logic [8:0]  i_card_colour;
  logic [7:0]  o_x;
  logic [6:0]  o_y;
  logic [2:0]  o_colour;
  logic        o_plot;
  logic        o_busy;
  logic        o_done;

  int nChecks;
  int nFails;
  int curT;
  int doneT;

  logic       expPlot    [DEPTH];
  logic [7:0] expX       [DEPTH];
  logic [6:0] expY       [DEPTH];
  logic [2:0] expC       [DEPTH];
  int         expCard    [DEPTH];
  int         expPlotNum [DEPTH];

  draw_cards #(
    .CARD_W    (CARD_W),
    .CARD_H    (CARD_H),
    .X_ORG     (X_ORG),
    .Y_ORG     (Y_ORG),
    .PITCH     (PITCH),
    .BORDER_COL(BORDER_COL)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (i_start),
    .i_card_idx   (i_card_idx),
    .i_card_colour(i_card_colour),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_colour     (o_colour),
    .o_plot       (o_plot),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s t=%0d got=%0h expected=%0h", tag, curT, actual, expected);
    end
  endtask

  // Reference model: t is cycles after the sampling edge of the request.
  // Cycle 1 loads card0; a drawn card spends one cycle loading, W*H pixels,
  // and one cycle advancing; a skipped card spends a load and an advance.
  task automatic buildModel(input logic [11:0] idx, input logic [8:0] col);
    int t;
    int id;
    int x0;
    int y0;
    int n;
    logic [2:0] fill;
    for (int i = 0; i < DEPTH; i++) begin
      expPlot[i]    = 1'b0;
      expX[i]       = '0;
      expY[i]       = '0;
      expC[i]       = '0;
      expCard[i]    = -1;
      expPlotNum[i] = 0;
    end
    t = 1;
    for (int c = 0; c < 3; c++) begin
      id   = int'(idx[4*c +: 4]);
      fill = col[3*c +: 3];
      if (id >= 1 && id <= 9) begin
        x0 = X_ORG + ((id - 1) % 3) * PITCH;
        y0 = Y_ORG + ((id - 1) / 3) * PITCH;
        n  = 0;
        for (int py = 0; py < CARD_H; py++) begin
          for (int px = 0; px < CARD_W; px++) begin
            t++;
            n++;
            expPlot[t]    = 1'b1;
            expX[t]       = 8'(x0 + px);
            expY[t]       = 7'(y0 + py);
            expC[t]       = (px == 0 || px == CARD_W - 1 || py == 0 || py == CARD_H - 1) ? BORDER_COL : fill;
            expCard[t]    = c;
            expPlotNum[t] = n;
          end
        end
      end
      t += 2;
    end
    doneT = t;
  endtask

  task automatic checkCycle(input int t);
    logic inGrid;
    checkOutput("plot",   32'(o_plot),   32'(expPlot[t]));
    checkOutput("x",      32'(o_x),      32'(expX[t]));
    checkOutput("y",      32'(o_y),      32'(expY[t]));
    checkOutput("colour", 32'(o_colour), 32'(expC[t]));
    checkOutput("busy",   32'(o_busy),   32'((t >= 1) && (t < doneT)));
    checkOutput("done",   32'(o_done),   32'(t == doneT));
    if (o_plot) begin
      inGrid = (int'(o_x) >= X_ORG) && (int'(o_x) <= X_MAX) &&
               (int'(o_y) >= Y_ORG) && (int'(o_y) <= Y_MAX);
      checkOutput("inGrid", 32'(inGrid), 32'd1);
    end else begin
      checkOutput("idleZero", 32'({o_x, o_y, o_colour}), 32'd0);
    end
  endtask

  // Runs one full draw sequence and compares every cycle until one past done.
  // preStarted: the request was already driven by the previous sequence.
  // disturb:    pulse start and scramble inputs while the DUT is busy.
  // chain:      request the next sequence in the first idle cycle after done.
  task automatic applyStimulus(input logic [11:0] idx, input logic [8:0] col,
                               input bit preStarted, input bit disturb, input bit chain,
                               input logic [11:0] nIdx, input logic [8:0] nCol);
    int pulses;
    pulses = 0;
    buildModel(idx, col);
    if (!preStarted) begin
      @(negedge clk);
      i_start       = 1'b1;
      i_card_idx    = idx;
      i_card_colour = col;
    end
    @(posedge clk);
    #1 i_start = 1'b0;
    for (int t = 0; t <= doneT + 1; t++) begin
      @(negedge clk);
      curT = t;
      checkCycle(t);
      i_start = 1'b0;
      if (disturb && t >= 1 && t <= doneT) begin
        i_card_idx    = 12'($urandom);
        i_card_colour = 9'($urandom);
        if ((t % 60) == 7 && pulses < 10) begin
          i_start = 1'b1;
          pulses++;
        end
      end
      if (t == doneT) i_start = disturb;
      if (t == doneT + 1 && chain) begin
        i_start       = 1'b1;
        i_card_idx    = nIdx;
        i_card_colour = nCol;
      end
    end
  endtask

  // Resets at the 100th pixel of card1 and checks the abort is immediate.
  task automatic resetMidDraw(input logic [11:0] idx, input logic [8:0] col);
    int target;
    target = -1;
    buildModel(idx, col);
    @(negedge clk);
    i_start       = 1'b1;
    i_card_idx    = idx;
    i_card_colour = col;
    @(posedge clk);
    #1 i_start = 1'b0;
    for (int t = 0; t <= doneT + 1 && target < 0; t++) begin
      @(negedge clk);
      curT = t;
      checkCycle(t);
      if (expCard[t] == 1 && expPlotNum[t] == 100) target = t;
    end
    checkOutput("reachedCard1Px100", 32'(target >= 0), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("rstOutputs", 32'({o_x, o_y, o_colour, o_plot, o_busy, o_done}), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("postRstIdle", 32'({o_plot, o_busy, o_done}), 32'd0);
    end
  endtask

  initial begin
    logic [11:0] rIdx;
    logic [8:0]  rCol;
    nChecks       = 0;
    nFails        = 0;
    curT          = -1;
    reset_n       = 1'b0;
    i_start       = 1'b0;
    i_card_idx    = '0;
    i_card_colour = '0;

    repeat (2) @(negedge clk);
    checkOutput("rstX",      32'(o_x),      32'd0);
    checkOutput("rstY",      32'(o_y),      32'd0);
    checkOutput("rstColour", 32'(o_colour), 32'd0);
    checkOutput("rstPlot",   32'(o_plot),   32'd0);
    checkOutput("rstBusy",   32'(o_busy),   32'd0);
    checkOutput("rstDone",   32'(o_done),   32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    $display("[TB] three valid cards");
    applyStimulus(12'h951, 9'b001_010_100, 1'b0, 1'b0, 1'b0, 12'h0, 9'h0);

    $display("[TB] two skipped slots");
    applyStimulus(12'h4C0, 9'b011_101_110, 1'b0, 1'b0, 1'b0, 12'h0, 9'h0);

    $display("[TB] start pulses and input changes while busy");
    applyStimulus(12'h951, 9'b001_010_100, 1'b0, 1'b1, 1'b0, 12'h0, 9'h0);

    $display("[TB] reset in the middle of card1");
    resetMidDraw(12'h372, 9'b110_011_001);
    applyStimulus(12'h372, 9'b110_011_001, 1'b0, 1'b0, 1'b0, 12'h0, 9'h0);

    $display("[TB] back-to-back requests");
    applyStimulus(12'h951, 9'b001_010_100, 1'b0, 1'b0, 1'b1, 12'h951, 9'b001_010_100);
    applyStimulus(12'h951, 9'b001_010_100, 1'b1, 1'b0, 1'b0, 12'h0, 9'h0);

    $display("[TB] duplicate indices");
    applyStimulus(12'h555, 9'b010_101_011, 1'b0, 1'b0, 1'b0, 12'h0, 9'h0);

    $display("[TB] random requests");
    for (int r = 0; r < 4; r++) begin
      rIdx = 12'($urandom);
      rCol = 9'($urandom);
      applyStimulus(rIdx, rCol, 1'b0, (r == 1), 1'b0, 12'h0, 9'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
